layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Paces layer_1 channel instances from the SPI byte stream. Latches each received byte,
//  emits one pixel-clock pulse of fixed width per pixel, counts pixels per frame and flushes
//  the pipeline with zero pixels at frame end. Saturates the channel-sum result and buffers
//  it in a small FIFO, which the SPI transmit side pops.
//  Sits between the SPI_slave shift logic and the layer_1 array.
// PARAMETERS
//  IMG_W     28  pixels per row
//  IMG_H     28  rows per frame
//  NCH       6   layer_1 channel instances summed
//  PCLK_HI   2   CLK cycles pxl_clk is held high (>=1)
//  PCLK_LO   2   CLK cycles pxl_clk is held low after each pulse (>=1)
//  DRAIN_PX  4   zero-pixel flush pulses issued after the last real pixel
//  FIFO_D    4   result FIFO depth (power of 2)
// PORTS
//  CLK          in   1          system clock
//  RESET        in   1          synchronous, active-high reset
//  frame_start  in   1          1-cycle strobe at SSEL assertion; clears the frame
//  byte_valid   in   1          1-cycle strobe: byte_in holds a new pixel
//  byte_in      in   8          received pixel
//  pxl_out      out  9          {1'b0,pixel} to layer_1 pxl_in
//  pxl_clk      out  1          pixel clock to layer_1
//  lyr_reset    out  1          reset to layer_1 (RESET | frame_start, registered)
//  lyr_valid    in   NCH        per-channel valid
//  lyr_out      in   NCH*9      per-channel result, ch0 in [8:0]
//  tx_pop       in   1          SPI side consumes tx_byte
//  tx_byte      out  8          FIFO head; 0 when empty
//  tx_empty     out  1          FIFO empty
//  frame_done   out  1          1-cycle strobe when drain completes
//  overflow     out  1          sticky: pixel or result dropped; cleared by RESET/frame_start
// BEHAVIOUR
//  Reset (RESET or frame_start): FSM=IDLE; counters, skid buffer and FIFO cleared.
//   pxl_out=0, pxl_clk=0, tx_byte=0, tx_empty=1, frame_done=0, overflow=0.
//   lyr_reset=1 in the cycle after the reset strobe, else 0.
//  byte_valid in the same cycle as frame_start is kept as pixel 0 of the new frame.
//  FSM:
//   IDLE: pixel pending -> HI (pxl_out<=pixel, pxl_clk<=1)
//   HI:   PCLK_HI cycles -> LO (pxl_clk<=0)
//   LO:   PCLK_LO cycles, then:
//         - pix_cnt<IMG_W*IMG_H and pixel pending -> HI
//         - pix_cnt<IMG_W*IMG_H, none pending -> IDLE
//         - pix_cnt==IMG_W*IMG_H -> DRAIN
//   DRAIN: DRAIN_PX HI/LO pulses with pxl_out=0, then DONE
//   DONE: frame_done=1 for one cycle; stays there and ignores byte_valid until frame_start
//  Timing and counting:
//   - Latency from byte_valid to pxl_clk rise is 1 CLK when IDLE.
//   - pix_cnt increments on each real-pixel HI entry. It has col/row sub-counters that wrap
//     at IMG_W, then at IMG_H.
//  Skid buffer: one entry. byte_valid while the entry is full -> byte dropped, overflow=1.
//  Result capture: on the CLK where pxl_clk falls, if &lyr_valid, form the sum.
//   - sum = unsigned sum of NCH 9-bit lanes, width 9+$clog2(NCH).
//   - The sum saturates to 8'hFF if >255 and is pushed to the FIFO.
//   - FIFO full -> result dropped, overflow=1.
//  FIFO: first-word fall-through. Pointers are $clog2(FIFO_D)+1 bits wide.
//   - tx_pop on empty is ignored.
//   - Simultaneous push and pop when full: the pop completes and the push is accepted.
//  A reset mid-pulse forces pxl_clk=0 in the next cycle. No partial result is pushed.
// STRUCTURE
//  Shared package layer_pkg: FSM state enum (IDLE,HI,LO,DRAIN,DONE), PXL_W=9, OUT_W=8.
//  Sub-module: result_fifo (sync FWFT FIFO, params WIDTH, DEPTH; used for the tx queue).
//  Summation tree and saturation stay inline.
// TESTING (use IMG_W=2, IMG_H=2, NCH=2, PCLK_HI=PCLK_LO=1, DRAIN_PX=2, FIFO_D=4)
//  1. Frame: frame_start, then bytes 10,20,30,40 spaced 8 CLK apart.
//     -> Exactly 6 pxl_clk pulses, pxl_out 10,20,30,40,0,0.
//     -> frame_done strobes once, 1 CLK after the 6th LO completes.
//  2. Sum: lyr_valid=2'b11, lanes 100 and 200 at a falling edge.
//     -> tx_byte=8'hFF (saturated), tx_empty=0.
//     -> Lanes 3 and 4 -> next entry is 7.
//  3. Skid: 3 byte_valid on consecutive CLKs while IDLE.
//     -> First two are pulsed in order, the third is dropped, overflow=1.
//  4. FIFO full: 5 results captured with no tx_pop.
//     -> Entries 1..4 retained, the 5th is dropped, overflow=1.
//     -> 4 pops return the entries in order, then tx_empty=1 and tx_byte=0.
//  5. Reset mid-pulse: RESET asserted while pxl_clk=1.
//     -> Next cycle pxl_clk=0, tx_empty=1, overflow=0.
//     -> lyr_reset=1 for exactly 1 CLK.
//  6. Restart: frame_start with byte_valid=1 (byte 55) in the same cycle during DONE.
//     -> pxl_out=55 with a pxl_clk rise 1 CLK later; pix_cnt=1.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types and constants for the layer_1 pixel sequencer.
//   seq_state_e : sequencer FSM states
//   PXL_W       : width of a layer_1 pixel / channel result lane
//   OUT_W       : width of a byte returned to the SPI transmit side
//   sat_byte()  : clamps an unsigned value to OUT_W bits
package layer_pkg;

  localparam int unsigned PXL_W = 9;
  localparam int unsigned OUT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StDrain,
    StDone
  } seq_state_e;

  function automatic logic [OUT_W-1:0] sat_byte(input logic [31:0] v);
    return (v > 32'd255) ? '1 : v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO for saturated channel sums.
// Ports:
//   clk, rst     : clock, synchronous active-high clear
//   push, din    : write request and data (dropped when full unless popping)
//   pop          : consume head (ignored when empty)
//   dout         : current head, 0 when empty
//   empty, full  : status flags
module result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Paces layer_1 channel instances from the SPI byte stream: one fixed-width pixel-clock
// pulse per received byte, zero-pixel drain pulses at frame end, and a saturated sum of
// the channel results queued for the SPI transmit side.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   frame_start         : strobe, clears the frame (a same-cycle byte becomes pixel 0)
//   byte_valid, byte_in : received pixel strobe and value
//   pxl_out, pxl_clk    : pixel and pixel clock to layer_1
//   lyr_reset           : registered RESET | frame_start to layer_1
//   lyr_valid, lyr_out  : per-channel valid and 9-bit results (ch0 in [8:0])
//   tx_pop              : SPI side consumes tx_byte
//   tx_byte, tx_empty   : result FIFO head (0 when empty) and empty flag
//   frame_done          : strobe when the drain completes
//   overflow            : sticky, a pixel or result was dropped
module layer_sequencer
  import layer_pkg::*;
#(
  parameter int unsigned IMG_W    = 28,
  parameter int unsigned IMG_H    = 28,
  parameter int unsigned NCH      = 6,
  parameter int unsigned PCLK_HI  = 2,
  parameter int unsigned PCLK_LO  = 2,
  parameter int unsigned DRAIN_PX = 4,
  parameter int unsigned FIFO_D   = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 frame_start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic [PXL_W-1:0]     pxl_out,
  output logic                 pxl_clk,
  output logic                 lyr_reset,
  input  logic [NCH-1:0]       lyr_valid,
  input  logic [NCH*PXL_W-1:0] lyr_out,
  input  logic                 tx_pop,
  output logic [OUT_W-1:0]     tx_byte,
  output logic                 tx_empty,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned COL_W = $clog2(IMG_W + 1);
  localparam int unsigned ROW_W = $clog2(IMG_H + 1);
  localparam int unsigned TMR_W = $clog2(PCLK_HI + PCLK_LO + 1);
  localparam int unsigned DRN_W = $clog2(DRAIN_PX + 1);
  localparam int unsigned SUM_W = PXL_W + $clog2(NCH);

  seq_state_e       state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [DRN_W-1:0] drain_cnt_q;
  logic             drain_hi_q;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             skid_full_q;
  logic [7:0]       skid_q;

  logic             rst, have_pix, start_px, skid_load, byte_drop;
  logic             pulse_fall, capture, res_drop, fifo_full;
  logic [7:0]       pix_sel;
  logic [SUM_W-1:0] lane_sum;
  logic [OUT_W-1:0] sat_sum;

  always_comb begin
    rst      = RESET | frame_start;
    have_pix = skid_full_q | byte_valid;
    // The skid entry is older than any byte arriving now, so it goes first.
    pix_sel  = skid_full_q ? skid_q : byte_in;
    start_px = have_pix &&
               ((state_q == StIdle) ||
                (state_q == StLo && tmr_q == '0 && pix_cnt_q != CNT_W'(NPIX)));
    // A full entry refuses new bytes even when it is being consumed this cycle.
    byte_drop = byte_valid && skid_full_q && (state_q != StDone);
    skid_load = byte_valid && !skid_full_q && (state_q != StDone) && !start_px;

    pulse_fall = (tmr_q == '0) &&
                 ((state_q == StHi) || (state_q == StDrain && drain_hi_q));
    lane_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      lane_sum = lane_sum + SUM_W'(lyr_out[i*PXL_W +: PXL_W]);
    end
    sat_sum  = sat_byte(32'(lane_sum));
    capture  = !rst && pulse_fall && (&lyr_valid);
    res_drop = capture && fifo_full && !tx_pop;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      drain_cnt_q <= '0;
      drain_hi_q  <= 1'b0;
      pix_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      skid_full_q <= frame_start & byte_valid & ~RESET;
      skid_q      <= byte_in;
      pxl_out     <= '0;
      pxl_clk     <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      lyr_reset   <= 1'b1;
    end else begin
      lyr_reset  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_drop || res_drop) begin
        overflow <= 1'b1;
      end

      if (start_px) begin
        skid_full_q <= 1'b0;
      end else if (skid_load) begin
        skid_full_q <= 1'b1;
        skid_q      <= byte_in;
      end

      unique case (state_q)
        StIdle: ;
        StHi: begin
          if (tmr_q == '0) begin
            pxl_clk <= 1'b0;
            state_q <= StLo;
            tmr_q   <= TMR_W'(PCLK_LO - 1);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        StLo: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end else if (pix_cnt_q == CNT_W'(NPIX)) begin
            state_q     <= StDrain;
            drain_hi_q  <= 1'b1;
            drain_cnt_q <= DRN_W'(1);
            pxl_out     <= '0;
            pxl_clk     <= 1'b1;
            tmr_q       <= TMR_W'(PCLK_HI - 1);
          end else if (!have_pix) begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end else if (drain_hi_q) begin
            pxl_clk    <= 1'b0;
            drain_hi_q <= 1'b0;
            tmr_q      <= TMR_W'(PCLK_LO - 1);
          end else if (drain_cnt_q == DRN_W'(DRAIN_PX)) begin
            state_q    <= StDone;
            frame_done <= 1'b1;
          end else begin
            drain_hi_q  <= 1'b1;
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
            pxl_clk     <= 1'b1;
            tmr_q       <= TMR_W'(PCLK_HI - 1);
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase

      // Launching a real pixel overrides the IDLE/LO decisions above.
      if (start_px) begin
        state_q   <= StHi;
        pxl_out   <= {1'b0, pix_sel};
        pxl_clk   <= 1'b1;
        tmr_q     <= TMR_W'(PCLK_HI - 1);
        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
        if (col_q == COL_W'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  result_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(FIFO_D)
  ) u_fifo (
    .clk  (CLK),
    .rst  (rst),
    .push (capture),
    .din  (sat_sum),
    .pop  (tx_pop),
    .dout (tx_byte),
    .empty(tx_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 2x2 image, two channels, 1-cycle pulse phases,
// two drain pulses and a 4-deep result FIFO. Inputs change on the falling edge; outputs
// are sampled on the falling edge.
module tb_layer_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, frame_start, byte_valid, tx_pop;
  logic [7:0]  byte_in;
  logic [8:0]  pxl_out;
  logic        pxl_clk, lyr_reset;
  logic [1:0]  lyr_valid;
  logic [17:0] lyr_out;
  logic [7:0]  tx_byte;
  logic        tx_empty, frame_done, overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rises = 0;
  int fall_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  logic prev_clk = 1'b0;
  logic [8:0] seen [8];

  always #5 CLK = ~CLK;

  layer_sequencer #(
    .IMG_W   (2),
    .IMG_H   (2),
    .NCH     (2),
    .PCLK_HI (1),
    .PCLK_LO (1),
    .DRAIN_PX(2),
    .FIFO_D  (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .frame_start(frame_start),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .pxl_out    (pxl_out),
    .pxl_clk    (pxl_clk),
    .lyr_reset  (lyr_reset),
    .lyr_valid  (lyr_valid),
    .lyr_out    (lyr_out),
    .tx_pop     (tx_pop),
    .tx_byte    (tx_byte),
    .tx_empty   (tx_empty),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; tracks pxl_clk edges, pixels at each rise and frame_done strobes.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (pxl_clk === 1'b1 && prev_clk === 1'b0) begin
      if (rises < 8) seen[rises] = pxl_out;
      rises++;
    end
    if (pxl_clk === 1'b0 && prev_clk === 1'b1) fall_cyc = cyc;
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_clk = pxl_clk;
  endtask

  task automatic clear_mon();
    rises    = 0;
    fall_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    byte_in    = v;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic strobe_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_level(input logic v);
    int n = 0;
    while (pxl_clk !== v && n < 40) begin
      step();
      n++;
    end
    chk("wait_pxl_clk", 32'(pxl_clk), 32'(v));
  endtask

  task automatic pop_one();
    tx_pop = 1'b1;
    step();
    tx_pop = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    tx_pop = 1'b0; lyr_valid = 2'b00; lyr_out = '0;

    // Reset state
    step(); step();
    chk("rst_lyr_reset", 32'(lyr_reset), 1);
    chk("rst_pxl_clk", 32'(pxl_clk), 0);
    chk("rst_pxl_out", 32'(pxl_out), 0);
    chk("rst_tx_empty", 32'(tx_empty), 1);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    RESET = 1'b0;
    step();
    chk("rst_lyr_reset_off", 32'(lyr_reset), 0);

    // Full frame: 4 real pixels and 2 drain pulses
    clear_mon();
    strobe_frame();
    chk("fs_lyr_reset", 32'(lyr_reset), 1);
    send_byte(8'd10);
    chk("lat_pxl_clk", 32'(pxl_clk), 1);
    chk("lat_pxl_out", 32'(pxl_out), 10);
    repeat (7) step();
    send_byte(8'd20); repeat (7) step();
    send_byte(8'd30); repeat (7) step();
    send_byte(8'd40); repeat (7) step();
    repeat (6) step();
    chk("frame_pulses", 32'(rises), 6);
    chk("frame_px0", 32'(seen[0]), 10);
    chk("frame_px1", 32'(seen[1]), 20);
    chk("frame_px2", 32'(seen[2]), 30);
    chk("frame_px3", 32'(seen[3]), 40);
    chk("frame_px4", 32'(seen[4]), 0);
    chk("frame_px5", 32'(seen[5]), 0);
    chk("frame_done_cnt", 32'(done_cnt), 1);
    chk("frame_done_time", 32'(done_cyc), 32'(fall_cyc + 1));
    chk("frame_no_push", 32'(tx_empty), 1);

    // DONE ignores bytes, then restart with a byte in the frame_start cycle
    send_byte(8'd99);
    repeat (3) step();
    chk("done_ignore_clk", 32'(pxl_clk), 0);
    chk("done_ignore_ovf", 32'(overflow), 0);
    frame_start = 1'b1; byte_valid = 1'b1; byte_in = 8'd55;
    step();
    frame_start = 1'b0; byte_valid = 1'b0;
    chk("restart_clk_low", 32'(pxl_clk), 0);
    step();
    chk("restart_clk", 32'(pxl_clk), 1);
    chk("restart_px", 32'(pxl_out), 55);
    chk("restart_cnt", 32'(dut.pix_cnt_q), 1);

    // Channel sum with saturation
    strobe_frame();
    lyr_valid = 2'b11;
    lyr_out   = {9'd200, 9'd100};
    send_byte(8'd1); repeat (3) step();
    chk("sum_sat", 32'(tx_byte), 255);
    chk("sum_not_empty", 32'(tx_empty), 0);
    lyr_out = {9'd4, 9'd3};
    send_byte(8'd2); repeat (3) step();
    lyr_valid = 2'b00;
    chk("sum_head_kept", 32'(tx_byte), 255);
    pop_one();
    chk("sum_second", 32'(tx_byte), 7);
    pop_one();
    chk("sum_drained", 32'(tx_empty), 1);

    // Skid buffer: third back-to-back byte is dropped
    strobe_frame();
    clear_mon();
    byte_valid = 1'b1;
    byte_in = 8'd1; step();
    byte_in = 8'd2; step();
    chk("skid_no_ovf_yet", 32'(overflow), 0);
    byte_in = 8'd3; step();
    byte_valid = 1'b0;
    repeat (6) step();
    chk("skid_pulses", 32'(rises), 2);
    chk("skid_px0", 32'(seen[0]), 1);
    chk("skid_px1", 32'(seen[1]), 2);
    chk("skid_ovf", 32'(overflow), 1);

    // FIFO full: fifth result is dropped
    strobe_frame();
    lyr_valid = 2'b11;
    for (int r = 1; r <= 5; r++) begin
      lyr_out = {9'd0, 9'(r)};
      if (r <= 4) send_byte(8'(100 + r));
      wait_level(1'b1);
      wait_level(1'b0);
      if (r == 4) chk("full_no_ovf", 32'(overflow), 0);
    end
    lyr_valid = 2'b00;
    chk("full_ovf", 32'(overflow), 1);
    chk("full_not_empty", 32'(tx_empty), 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("full_pop%0d", i), 32'(tx_byte), 32'(i));
      pop_one();
    end
    chk("full_empty", 32'(tx_empty), 1);
    chk("full_empty_byte", 32'(tx_byte), 0);

    // RESET while pxl_clk is high
    strobe_frame();
    lyr_valid = 2'b11;
    lyr_out   = {9'd1, 9'd1};
    byte_valid = 1'b1;
    byte_in = 8'd1; step();
    byte_in = 8'd2; step();
    byte_in = 8'd3; step();
    byte_valid = 1'b0;
    chk("mid_pre_clk", 32'(pxl_clk), 1);
    chk("mid_pre_fifo", 32'(tx_empty), 0);
    chk("mid_pre_ovf", 32'(overflow), 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_clk", 32'(pxl_clk), 0);
    chk("mid_empty", 32'(tx_empty), 1);
    chk("mid_ovf", 32'(overflow), 0);
    chk("mid_lyr_reset", 32'(lyr_reset), 1);
    chk("mid_tx_byte", 32'(tx_byte), 0);
    step();
    chk("mid_lyr_reset_off", 32'(lyr_reset), 0);
    chk("mid_no_partial", 32'(tx_empty), 1);
    chk("mid_clk_idle", 32'(pxl_clk), 0);
    lyr_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
